// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared uart_tx: one requester holds the
// transmitter for a whole packet, with forced release on an idle owner.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NREQ-1:0]   iReqValid,
  input  logic [NREQ*8-1:0] iReqByte,
  input  logic [NREQ-1:0]   iReqLast,
  output logic [NREQ-1:0]   oReqReady,
  output logic [NREQ-1:0]   oGrant,
  output logic              oTxStart,
  output logic [7:0]        oTxByte,
  input  logic              iTxBusy,
  input  logic              iTxDone,
  output logic              oIdle
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] S_ARB  = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(IDLE_TIMEOUT);
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  logic [1:0]      rState, nState;
  logic [IDXW-1:0] rLast, nLast;
  logic [IDXW-1:0] rOwner, nOwner;
  logic [CNTW-1:0] rCnt, nCnt;
  logic            rLastFlag, nLastFlag;
  logic [NREQ-1:0] nGrant, nReady;
  logic            nStart, nIdle;
  logic [7:0]      nByte;

  logic            found;
  logic [IDXW-1:0] pick, idx;
  logic [7:0]      ownByte;

  assign ownByte = iReqByte[{rOwner, 3'b000} +: 8];

  // first valid requester strictly after rLast, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDXW'((int'(rLast) + i) % NREQ);
      if (!found && iReqValid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    nState    = rState;
    nLast     = rLast;
    nOwner    = rOwner;
    nCnt      = rCnt;
    nLastFlag = rLastFlag;
    nGrant    = oGrant;
    nReady    = '0;
    nStart    = 1'b0;
    nByte     = oTxByte;
    case (rState)
      S_ARB: begin
        nGrant = '0;
        if (found) begin
          nGrant = ONE << pick;
          nOwner = pick;
          nCnt   = '0;
          nState = S_SEND;
        end
      end
      S_SEND: begin
        if (iReqValid[rOwner] && !iTxBusy) begin
          nStart         = 1'b1;
          nByte          = ownByte;
          nReady[rOwner] = 1'b1;
          nLastFlag      = iReqLast[rOwner];
          nCnt           = '0;
          nState         = S_WAIT;
        end else if (!iReqValid[rOwner]) begin
          if (rCnt != CNT_MAX) nCnt = rCnt + 1'b1;
          if (nCnt == CNT_MAX) begin
            nGrant = '0;
            nLast  = rOwner;
            nState = S_ARB;
          end
        end
      end
      S_WAIT: begin
        if (iTxDone) begin
          if (rLastFlag) begin
            nGrant = '0;
            nLast  = rOwner;
            nState = S_ARB;
          end else begin
            nState = S_SEND;
          end
        end
      end
      default: begin
        nGrant = '0;
        nState = S_ARB;
      end
    endcase
    nIdle = (nState == S_ARB) && (nGrant == '0);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rState    <= S_ARB;
      rLast     <= IDXW'(NREQ - 1);
      rOwner    <= '0;
      rCnt      <= '0;
      rLastFlag <= 1'b0;
      oGrant    <= '0;
      oReqReady <= '0;
      oTxStart  <= 1'b0;
      oTxByte   <= '0;
      oIdle     <= 1'b1;
    end else begin
      rState    <= nState;
      rLast     <= nLast;
      rOwner    <= nOwner;
      rCnt      <= nCnt;
      rLastFlag <= nLastFlag;
      oGrant    <= nGrant;
      oReqReady <= nReady;
      oTxStart  <= nStart;
      oTxByte   <= nByte;
      oIdle     <= nIdle;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level requester queues, a uart_tx
// stand-in and a transaction model of round-robin packet ownership.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic              iClk = 1'b0;
  logic              iRst;
  logic [NREQ-1:0]   iReqValid;
  logic [NREQ*8-1:0] iReqByte;
  logic [NREQ-1:0]   iReqLast;
  logic [NREQ-1:0]   oReqReady;
  logic [NREQ-1:0]   oGrant;
  logic              oTxStart;
  logic [7:0]        oTxByte;
  logic              iTxBusy;
  logic              iTxDone;
  logic              oIdle;

  always #5 iClk = ~iClk;

  uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .iReqByte(iReqByte),
    .iReqLast(iReqLast), .oReqReady(oReqReady),
    .oGrant(oGrant), .oTxStart(oTxStart),
    .oTxByte(oTxByte), .iTxBusy(iTxBusy),
    .iTxDone(iTxDone), .oIdle(oIdle)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } ent_t;

  ent_t q[NREQ][$];
  logic [NREQ-1:0] held;

  int errs = 0;
  int checks = 0;

  // model state
  int ptr;
  logic [NREQ-1:0] mGrant;
  bit waitDone, lastAcc;
  int idleCnt;
  logic [7:0] mByte;

  // uart_tx stand-in
  bit uBusy, forceBusy;
  int uCnt;

  // observation logs
  int edgeN, startCnt, doneEdge, relEdge;
  logic [NREQ-1:0] prevObsG;
  int accReq[$];
  logic [7:0] accByte[$];
  int obsGrant[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(int p, logic [NREQ-1:0] v);
    for (int i = 1; i <= NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic int oneIdx(logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++)
      if (g[i]) return i;
    return 0;
  endfunction

  function automatic bit allEmpty();
    for (int r = 0; r < NREQ; r++)
      if (q[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    logic [NREQ-1:0] pv, eGrant, eReady;
    logic pBusy, pDone, pRst, eStart;
    int own, w;
    ent_t e;
    pv = iReqValid; pBusy = iTxBusy;
    pDone = iTxDone; pRst = iRst;
    @(posedge iClk); #1;
    edgeN++;
    eReady = '0; eStart = 1'b0; eGrant = mGrant;
    if (pRst) begin
      eGrant = '0; mByte = '0; ptr = NREQ - 1;
      waitDone = 0; lastAcc = 0; idleCnt = 0;
    end else if (mGrant == '0) begin
      w = rr(ptr, pv);
      if (w >= 0) begin
        eGrant = NREQ'(1) << w;
        idleCnt = 0; waitDone = 0;
      end
    end else begin
      own = oneIdx(mGrant);
      if (waitDone) begin
        if (pDone) begin
          waitDone = 0;
          if (lastAcc) begin
            eGrant = '0; ptr = own;
          end
        end
      end else if (pv[own] && !pBusy) begin
        eReady[own] = 1'b1; eStart = 1'b1;
        if (q[own].size() > 0) begin
          e = q[own].pop_front();
          mByte = e.b; lastAcc = e.last;
        end
        waitDone = 1; idleCnt = 0; held[own] = 1'b1;
      end else if (!pv[own]) begin
        idleCnt++;
        if (idleCnt == TO) begin
          eGrant = '0; ptr = own;
        end
      end
    end
    chk("grant", oGrant, eGrant);
    chk("ready", oReqReady, eReady);
    chk("start", oTxStart, eStart);
    chk("txbyte", oTxByte, mByte);
    chk("idle", oIdle, eGrant == '0);
    mGrant = eGrant;
    if (prevObsG == '0 && oGrant != '0) obsGrant.push_back(oneIdx(oGrant));
    if (prevObsG != '0 && oGrant == '0) relEdge = edgeN;
    prevObsG = oGrant;
    if (oReqReady != '0) begin
      accReq.push_back(oneIdx(oReqReady));
      accByte.push_back(oTxByte);
    end
    if (pDone) doneEdge = edgeN;
    if (oTxStart) startCnt++;
    iTxDone = 1'b0;
    if (pRst) begin
      uBusy = 0; held = '0;
    end else if (oTxStart) begin
      uBusy = 1; uCnt = $urandom_range(3, 12);
    end else if (uBusy) begin
      uCnt--;
      if (uCnt == 0) begin
        uBusy = 0; iTxDone = 1'b1;
      end
    end
    iTxBusy = uBusy | forceBusy;
    for (int r = 0; r < NREQ; r++) begin
      if (held[r]) held[r] = 1'b0;
      else if (q[r].size() > 0) begin
        iReqValid[r] = 1'b1;
        iReqByte[r*8 +: 8] = q[r][0].b;
        iReqLast[r] = q[r][0].last;
      end else begin
        iReqValid[r] = 1'b0;
      end
    end
  endtask

  task automatic runIdle(input int maxc);
    int n;
    n = 0;
    while (!(allEmpty() && mGrant == '0 && !waitDone) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) chk("run_bound", 0, 1);
    step();
  endtask

  task automatic clearLogs();
    accReq.delete(); accByte.delete(); obsGrant.delete();
  endtask

  task automatic doReset();
    for (int r = 0; r < NREQ; r++) q[r].delete();
    forceBusy = 0;
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    step();
    clearLogs();
  endtask

  initial begin
    int n, s0, len;
    iRst = 1'b1; iReqValid = '0; iReqByte = '0; iReqLast = '0;
    iTxBusy = 1'b0; iTxDone = 1'b0; held = '0; forceBusy = 0;
    ptr = NREQ - 1; mGrant = '0; waitDone = 0; lastAcc = 0;
    idleCnt = 0; mByte = '0; uBusy = 0; uCnt = 0;
    edgeN = 0; startCnt = 0; doneEdge = 0; relEdge = 0; prevObsG = '0;
    step();
    step();
    chk("rst_idle", oIdle, 1);
    chk("rst_grant", oGrant, 0);
    iRst = 1'b0;
    step();

    // single packet from r1
    clearLogs();
    q[1].push_back('{8'h41, 1'b0});
    q[1].push_back('{8'h42, 1'b1});
    runIdle(200);
    chk("pkt_n", accReq.size(), 2);
    if (accReq.size() == 2) begin
      chk("pkt_r0", accReq[0], 1); chk("pkt_b0", accByte[0], 8'h41);
      chk("pkt_r1", accReq[1], 1); chk("pkt_b1", accByte[1], 8'h42);
    end
    chk("pkt_idle", oIdle, 1);

    // round robin from reset pointer, then from rLast=0
    doReset();
    for (int r = 0; r < NREQ; r++) q[r].push_back('{8'(8'h30 + r), 1'b1});
    runIdle(400);
    chk("rr_n", obsGrant.size(), 4);
    for (int i = 0; i < 4 && i < obsGrant.size(); i++) chk("rr_ord", obsGrant[i], i);
    q[0].push_back('{8'h50, 1'b1});
    runIdle(200);
    clearLogs();
    q[0].push_back('{8'h60, 1'b1});
    q[2].push_back('{8'h62, 1'b1});
    runIdle(200);
    chk("rr2_n", obsGrant.size(), 2);
    if (obsGrant.size() == 2) begin
      chk("rr2_a", obsGrant[0], 2); chk("rr2_b", obsGrant[1], 0);
    end

    // packet lock against a waiting r3
    doReset();
    q[0].push_back('{8'hA0, 1'b0});
    q[0].push_back('{8'hA1, 1'b0});
    q[0].push_back('{8'hA2, 1'b1});
    q[3].push_back('{8'hB3, 1'b1});
    runIdle(400);
    chk("lock_n", accReq.size(), 4);
    if (accReq.size() == 4) begin
      chk("lock_0", accReq[2], 0);
      chk("lock_3", accReq[3], 3);
      chk("lock_b", accByte[3], 8'hB3);
    end

    // timeout: r2 sends a non-last byte then goes silent
    doReset();
    q[2].push_back('{8'h55, 1'b0});
    n = 0;
    while (accReq.size() == 0 && n < 50) begin step(); n++; end
    chk("to_acc", accReq.size(), 1);
    q[3].push_back('{8'h66, 1'b1});
    runIdle(300);
    chk("to_cycles", relEdge - doneEdge >= 0 ? 0 : 1, 0);
    chk("to_gap", obsGrant.size() == 2 ? 0 : 1, 0);
    if (obsGrant.size() == 2) chk("to_next", obsGrant[1], 3);
    if (accByte.size() == 2) chk("to_byte", accByte[1], 8'h66);

    // busy gating
    doReset();
    forceBusy = 1;
    q[1].push_back('{8'h77, 1'b1});
    s0 = startCnt;
    repeat (20) step();
    chk("busy_none", startCnt - s0, 0);
    forceBusy = 0;
    runIdle(200);
    chk("busy_one", startCnt - s0, 1);

    // reset while waiting on uart_tx
    doReset();
    q[1].push_back('{8'h10, 1'b0});
    q[1].push_back('{8'h11, 1'b1});
    s0 = startCnt; n = 0;
    while (startCnt == s0 && n < 50) begin step(); n++; end
    step(); step();
    for (int r = 0; r < NREQ; r++) q[r].delete();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    chk("mid_grant", oGrant, 0);
    chk("mid_start", oTxStart, 0);
    chk("mid_byte", oTxByte, 0);
    chk("mid_idle", oIdle, 1);
    clearLogs();
    q[1].push_back('{8'h20, 1'b1});
    q[0].push_back('{8'h21, 1'b1});
    runIdle(300);
    if (obsGrant.size() > 0) chk("mid_first", obsGrant[0], 0);
    else chk("mid_first_n", 0, 1);

    // random traffic
    doReset();
    repeat (2000) begin
      for (int r = 0; r < NREQ; r++) begin
        if (q[r].size() == 0 && $urandom_range(0, 15) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++)
            q[r].push_back('{8'($urandom), k == len - 1});
        end
      end
      forceBusy = ($urandom_range(0, 9) == 0);
      step();
    end
    forceBusy = 0;
    runIdle(2000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
